multireg_bank: RTL

//   Parametrised bank of NUM_REGS registers, each WIDTH bits, loaded from a shared Data_Bus.

---
 rtl/multireg_bank.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/multireg_bank.sv
// -----------------------------------------------------------------------------
// multireg_bank
//   Parametrised bank of NUM_REGS registers of WIDTH bits, loaded from a shared
//   data bus. Registers are written in two ways: by direct per-register write
//   enables, or by a sequenced burst that fills reg 0 .. NUM_REGS-1 in order
//   under valid/ready handshaking, with abort. A registered read-back port
//   returns one register, selected by address.
//
//   Optional feature (compile-time macro MULTIREG_SHADOW_EN):
//     defined   - burst words collect in a shadow array. All visible registers
//                 load from it on the edge that accepts the last word. An abort
//                 leaves the visible registers untouched.
//     undefined - burst words write the visible registers immediately. No
//                 shadow storage is built.
//
// Ports
//   Clock        in   rising-edge clock
//   Reset        in   asynchronous, active-low reset
//   Data_Bus     in   [WIDTH]           shared write data
//   Wr_En        in   [NUM_REGS]        direct write enables, bit i -> reg i
//   Burst_Start  in   start a burst at reg 0 (taken in IDLE only)
//   Burst_Valid  in   Data_Bus holds a burst word
//   Burst_Abort  in   terminate the active burst
//   Burst_Ready  out  bank accepts a burst word this cycle
//   Burst_Done   out  one-cycle pulse after a complete burst
//   Busy         out  burst in progress (BURST or DONE)
//   Rd_Addr      in   [AW]              read-back select
//   Rd_Data      out  [WIDTH]           registered read-back data (0 if out of range)
//   Regs         out  [NUM_REGS*WIDTH]  all registers, reg i at [i*WIDTH +: WIDTH]
// -----------------------------------------------------------------------------
module multireg_bank #(
  parameter int               WIDTH     = 8,
  parameter int               NUM_REGS  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              AW        = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [WIDTH-1:0]          Data_Bus,
  input  logic [NUM_REGS-1:0]       Wr_En,
  input  logic                      Burst_Start,
  input  logic                      Burst_Valid,
  input  logic                      Burst_Abort,
  output logic                      Burst_Ready,
  output logic                      Burst_Done,
  output logic                      Busy,
  input  logic [AW-1:0]             Rd_Addr,
  output logic [WIDTH-1:0]          Rd_Data,
  output logic [NUM_REGS*WIDTH-1:0] Regs
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  // A burst word is taken only when no abort comes in the same cycle.
  // An abort drops that word.
  logic burst_accept;
  logic burst_last;

  assign burst_accept = (state_q == S_BURST) && Burst_Valid && !Burst_Abort;
  assign burst_last   = burst_accept && (ptr_q == AW'(NUM_REGS - 1));

  // ---------------------------------------------------------------------------
  // Burst sequencer: next state and pointer
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (Burst_Start) begin
          state_d = S_BURST;
          ptr_d   = '0;
        end
      end
      S_BURST: begin
        if (Burst_Abort) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end else if (Burst_Valid) begin
          if (burst_last) begin
            state_d = S_DONE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end
      end
      S_DONE: begin
        // A Start here is ignored; the bank always returns to IDLE.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

`ifdef MULTIREG_SHADOW_EN
  // ---------------------------------------------------------------------------
  // Shadow array. It is not cleared on abort or on reset. The next burst fills
  // every entry before the commit reads it, so stale contents never show.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] shadow_q [NUM_REGS];

  // NOTE: storage arrays have no reset. Only the control state needs one, and
  // leaving the array out of reset lets it map to plain flops or RAM.
  always_ff @(posedge Clock) begin
    if (burst_accept) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ptr_q == AW'(i)) shadow_q[i] <= Data_Bus;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Register write arbitration. Direct writes come first. The burst path comes
  // last so that it wins a collision on the same register.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (Wr_En[i]) regs_d[i] = Data_Bus;
    end
`ifdef MULTIREG_SHADOW_EN
    // Commit: the last word comes straight from the bus. It has not reached
    // the shadow array yet.
    if (burst_last) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_d[i] = (i == NUM_REGS - 1) ? Data_Bus : shadow_q[i];
      end
    end
`else
    if (burst_accept) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ptr_q == AW'(i)) regs_d[i] = Data_Bus;
      end
    end
`endif
  end

  // Read-back mux. An address that matches no register (NUM_REGS not a power
  // of two) returns zero.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (Rd_Addr == AW'(i)) rd_data_d = regs_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Each flop then
  // samples pre-edge values, and read-back sees the old register contents.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      rd_data_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rd_data_q <= rd_data_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from the registered state, so glitch-free)
  // ---------------------------------------------------------------------------
  assign Burst_Ready = (state_q == S_BURST);
  assign Burst_Done  = (state_q == S_DONE);
  assign Busy        = (state_q != S_IDLE);
  assign Rd_Data     = rd_data_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign Regs[g*WIDTH +: WIDTH] = regs_q[g];
  end

endmodule
